// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants and IF/ID bundle type for the pipelined core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [31:0] C_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] C_IM_BASE   = 32'h0000_3000;
  localparam int unsigned C_IM_DEPTH  = 4096;
  localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        adel;
  } if_id_t;

  localparam int unsigned C_IF_ID_W = $bits(if_id_t);

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module   : if_id_reg
// Brief    : Pipeline register with clear-over-stall priority and async reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = C_IF_ID_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] bubble,
  output logic [WIDTH-1:0] q,
  output logic             load
);

  logic [WIDTH-1:0] r_q;

  // Clear beats stall so a flushed stage never keeps a stale instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= bubble;
    end else if (!stall) begin
      r_q <= d;
    end
  end

  assign q    = r_q;
  assign load = !clr && !stall;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : IF stage: PC register, next-PC mux, fetch error check, IF/ID reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC,
  parameter logic [31:0] IM_BASE  = C_IM_BASE,
  parameter int unsigned IM_DEPTH = C_IM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  input  logic        stall,
  input  logic        clr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        id_adel,
  output logic [31:0] fetch_cnt
);

  // One bit wider than the address so a window ending at 2^32 still compares.
  localparam logic [32:0] C_IM_END = {1'b0, IM_BASE} + (33'(IM_DEPTH) << 2);

  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic        w_adel;
  logic        w_load;
  logic [31:0] r_fetch_cnt;
  if_id_t      w_fetch;
  if_id_t      w_bubble;
  if_id_t      w_id;

  assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) ||
                  ({1'b0, r_pc} >= C_IM_END);

  // A stalled redirect is dropped here; ID re-asserts it once the stall ends.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (stall) begin
      w_next_pc = r_pc;
    end else if (redirect_valid) begin
      w_next_pc = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  always_comb begin
    w_fetch.instr  = w_adel ? C_NOP_INSTR : im_instr;
    w_fetch.pc     = r_pc;
    w_fetch.valid  = 1'b1;
    w_fetch.adel   = w_adel;
    w_bubble.instr = C_NOP_INSTR;
    w_bubble.pc    = r_pc;
    w_bubble.valid = 1'b0;
    w_bubble.adel  = 1'b0;
  end

  if_id_reg #(
    .WIDTH (C_IF_ID_W)
  ) u_if_id_reg (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .clr    (clr),
    .d      (w_fetch),
    .bubble (w_bubble),
    .q      (w_id),
    .load   (w_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_cnt <= 32'd0;
    end else if (w_load) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign im_pc     = r_pc;
  assign if_pc     = r_pc;
  assign id_instr  = w_id.instr;
  assign id_pc     = w_id.pc;
  assign id_valid  = w_id.valid;
  assign id_adel   = w_id.adel;
  assign fetch_cnt = r_fetch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit against a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] C_BASE  = 32'h0000_3000;
  localparam int unsigned C_DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic        stall;
  logic        clr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        id_adel;
  logic [31:0] fetch_cnt;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] m_pc, m_instr, m_idpc, m_cnt;
  logic        m_valid, m_adel;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .im_pc          (im_pc),
    .im_instr       (im_instr),
    .stall          (stall),
    .clr            (clr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_pc          (if_pc),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_valid       (id_valid),
    .id_adel        (id_adel),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [161:0] dut_vec();
    return {im_pc, if_pc, id_instr, id_pc, id_valid, id_adel, fetch_cnt};
  endfunction

  function automatic logic [161:0] mdl_vec();
    return {m_pc, m_pc, m_instr, m_idpc, m_valid, m_adel, m_cnt};
  endfunction

  function automatic logic addr_bad(input logic [31:0] pc);
    if (pc % 4 != 0) return 1'b1;
    if (pc < C_BASE) return 1'b1;
    return ((pc - C_BASE) / 4) >= C_DEPTH;
  endfunction

  task automatic m_reset();
    m_pc = C_BASE; m_instr = 0; m_idpc = 0; m_valid = 0; m_adel = 0; m_cnt = 0;
  endtask

  // Advance the model with the inputs present before the edge, then clock the DUT.
  task automatic tick();
    logic bad;
    bad = addr_bad(m_pc);
    if (clr) begin
      m_instr = 0; m_idpc = m_pc; m_valid = 0; m_adel = 0;
    end else if (!stall) begin
      m_instr = bad ? 32'h0 : im_instr;
      m_idpc  = m_pc; m_valid = 1; m_adel = bad;
      m_cnt   = m_cnt + 1;
    end
    if (!stall) m_pc = redirect_valid ? redirect_pc : m_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; clr = 0; redirect_valid = 0; redirect_pc = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); im_instr = 32'h3C01_1234;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_reset();
    n_total++;
    if (dut_vec() !== {32'h3000, 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_total++;
      if (if_pc !== 32'h3000 + 32'(4 * k) || id_pc !== 32'h3000 + 32'(4 * (k - 1)) ||
          id_valid !== 1'b1 || id_instr !== 32'h3C01_1234 || fetch_cnt !== 32'(k)) begin
        n_bad++; $display("FAIL seq_%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] slot_pc;
    slot_pc = if_pc;
    redirect_valid = 1; redirect_pc = 32'h3040;
    tick();
    redirect_valid = 0;
    n_total++;
    if (if_pc !== 32'h3040 || id_pc !== slot_pc || dut_vec() !== mdl_vec()) begin
      n_bad++; $display("FAIL redirect_slot got=%h exp=%h", dut_vec(), mdl_vec());
    end
    tick();
    n_total++;
    if (id_pc !== 32'h3040 || dut_vec() !== mdl_vec()) begin
      n_bad++; $display("FAIL redirect_target got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_stall_redirect();
    logic [161:0] frozen;
    frozen = dut_vec();
    stall = 1; redirect_valid = 1; redirect_pc = 32'h3080;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (dut_vec() !== frozen) begin
        n_bad++; $display("FAIL stall_hold_%0d got=%h exp=%h", k, dut_vec(), frozen);
      end
    end
    stall = 0;
    tick();
    redirect_valid = 0;
    n_total++;
    if (if_pc !== 32'h3080 || dut_vec() !== mdl_vec()) begin
      n_bad++; $display("FAIL stall_release got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_stall_clr();
    logic [31:0] pc0, cnt0;
    im_instr = 32'h0000_0021;
    tick();
    n_total++;
    if (id_instr !== 32'h0000_0021 || dut_vec() !== mdl_vec()) begin
      n_bad++; $display("FAIL pre_clr got=%h exp=%h", dut_vec(), mdl_vec());
    end
    pc0 = if_pc; cnt0 = fetch_cnt;
    stall = 1; clr = 1; redirect_valid = 1; redirect_pc = 32'h3100;
    tick();
    idle_inputs();
    n_total++;
    if (id_instr !== 32'h0 || id_valid !== 1'b0 || id_adel !== 1'b0 || id_pc !== pc0 ||
        if_pc !== pc0 || fetch_cnt !== cnt0) begin
      n_bad++; $display("FAIL stall_clr got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_adel();
    logic [31:0] targets [5];
    logic        bad_exp [5];
    targets = '{32'h0000_2FFC, 32'h0000_3002, 32'h0000_7000, 32'h0000_6FFC, 32'hFFFF_FFFC};
    bad_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    im_instr = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      redirect_valid = 1; redirect_pc = targets[k];
      tick();
      redirect_valid = 0;
      tick();
      n_total++;
      if (id_pc !== targets[k] || id_adel !== bad_exp[k] ||
          id_instr !== (bad_exp[k] ? 32'h0 : 32'hFFFF_FFFF) || dut_vec() !== mdl_vec()) begin
        n_bad++; $display("FAIL adel_%h got=%h exp=%h", targets[k], dut_vec(), mdl_vec());
      end
    end
    n_total++;
    if (if_pc !== 32'h0) begin
      n_bad++; $display("FAIL pc_wrap got=%h exp=%h", if_pc, 32'h0);
    end
    tick();
    n_total++;
    if (id_pc !== 32'h0 || id_adel !== 1'b1 || id_instr !== 32'h0) begin
      n_bad++; $display("FAIL adel_zero got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_async_reset();
    im_instr = 32'h1234_5678;
    redirect_valid = 1; redirect_pc = 32'h3050;
    tick();
    redirect_valid = 1; redirect_pc = 32'h3200; stall = 1;
    tick();
    #2 reset = 1;
    #1;
    m_reset();
    n_total++;
    if (dut_vec() !== {32'h3000, 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), mdl_vec());
    end
    @(posedge clk);
    #1 reset = 0; idle_inputs();
    tick();
    n_total++;
    if (id_pc !== 32'h3000 || id_valid !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_bad++; $display("FAIL post_reset got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      im_instr       = $urandom;
      stall          = ($urandom_range(0, 3) == 0);
      clr            = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = C_BASE + 32'($urandom_range(0, C_DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
        default: redirect_pc = C_BASE + 32'($urandom_range(0, C_DEPTH - 1) * 4);
      endcase
      tick();
      n_total++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++; errs++;
        if (errs <= 5) $display("FAIL random_%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_redirect();
    test_stall_clr();
    test_adel();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
